// File: rtl/zynq_axi_mem_model.sv
// AXI4 slave memory model for the cosim harness (PL master port).
// Independent read and write channels, one outstanding transaction each.
// Ports:
//   aclk/aresetn             clock, async active-low reset
//   aw*/w*/b*                write address, data and response channels
//   ar*/r*                   read address and data channels
// Bursts: FIXED, INCR, WRAP (2/4/8/16 beats). Reserved bursts and
// out-of-window beats answer SLVERR; the read path has a fixed latency.
//
// state  | meaning
// W_IDLE | awready high, waiting for a write address
// W_DATA | wready high, accepting beats until wlast
// W_RESP | bvalid high until bready
// R_IDLE | arready high, waiting for a read address
// R_WAIT | counting read_latency_p idle cycles
// R_DATA | rvalid high, one beat per handshake until rlast
module zynq_axi_mem_model #(
  parameter int                      id_width_p     = 6,
  parameter int                      addr_width_p   = 32,
  parameter int                      data_width_p   = 64,
  parameter int                      len_width_p    = 4,
  parameter int                      mem_els_p      = 1024,
  parameter logic [addr_width_p-1:0] base_addr_p    = '0,
  parameter int                      read_latency_p = 2,
  parameter logic [data_width_p-1:0] init_data_p    = '0
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [id_width_p-1:0]     awid,
  input  logic [addr_width_p-1:0]   awaddr,
  input  logic [len_width_p-1:0]    awlen,
  input  logic [1:0]                awburst,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [data_width_p-1:0]   wdata,
  input  logic [data_width_p/8-1:0] wstrb,
  input  logic                      wlast,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [id_width_p-1:0]     bid,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [id_width_p-1:0]     arid,
  input  logic [addr_width_p-1:0]   araddr,
  input  logic [len_width_p-1:0]    arlen,
  input  logic [1:0]                arburst,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [id_width_p-1:0]     rid,
  output logic [data_width_p-1:0]   rdata,
  output logic [1:0]                rresp,
  output logic                      rlast,
  output logic                      rvalid,
  input  logic                      rready
);

  localparam int          BYTES  = data_width_p / 8;
  localparam int          OFFW   = $clog2(BYTES);
  localparam int          IDXW   = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
  localparam logic [63:0] SPAN   = 64'(mem_els_p) * 64'(BYTES);
  localparam int          LATW   = $clog2(read_latency_p + 2);
  // R_WAIT exits when the counter reads zero, so it is loaded with latency-1.
  localparam int          LAT_LD = (read_latency_p > 0) ? read_latency_p - 1 : 0;
  localparam bit          LAT0   = (read_latency_p == 0);

  typedef logic [addr_width_p-1:0] addr_t;
  typedef logic [len_width_p-1:0]  len_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

  function automatic logic in_range(input addr_t a);
    logic [addr_width_p:0] off;
    off = {1'b0, a} - {1'b0, base_addr_p};
    return !off[addr_width_p] && (64'(off[addr_width_p-1:0]) < SPAN);
  endfunction

  function automatic logic [IDXW-1:0] word_idx(input addr_t a);
    addr_t off;
    off = (a - base_addr_p) >> OFFW;
    return IDXW'(off);
  endfunction

  function automatic logic burst_legal(input len_t len, input logic [1:0] burst);
    case (burst)
      2'b00, 2'b01: return 1'b1;
      2'b10: return (len == len_t'(1)) || (len == len_t'(3)) ||
                    (len == len_t'(7)) || (len == len_t'(15));
      default: return 1'b0;
    endcase
  endfunction

  function automatic addr_t next_addr(input addr_t a, input len_t len, input logic [1:0] burst);
    addr_t sz, bnd, nxt;
    nxt = a + addr_t'(BYTES);
    sz  = (addr_t'(len) + addr_t'(1)) << OFFW;
    bnd = a & ~(sz - addr_t'(1));
    case (burst)
      2'b00: nxt = a;
      2'b10: if (nxt == bnd + sz) nxt = bnd;
      default: ;
    endcase
    return nxt;
  endfunction

  // Contents survive reset; only the declaration sets them.
  logic [data_width_p-1:0] mem_q [mem_els_p] = '{default: init_data_p};

  w_state_e              w_state_q;
  addr_t                 waddr_q;
  len_t                  wlen_q;
  logic [1:0]            wburst_q;
  logic                  wlegal_q, werr_q;
  logic [len_width_p:0]  wbeat_q;   // one bit wider so overrun beats are seen
  logic                  awready_q, wready_q, bvalid_q;
  logic [id_width_p-1:0] bid_q;
  logic [1:0]            bresp_q;

  r_state_e              r_state_q;
  addr_t                 raddr_q;
  len_t                  rlen_q, rbeat_q;
  logic [1:0]            rburst_q;
  logic                  rlegal_q;
  logic [LATW-1:0]       rlat_q;
  logic                  arready_q, rvalid_q, rlast_q;
  logic [id_width_p-1:0] rid_q;
  logic [data_width_p-1:0] rdata_q;
  logic [1:0]            rresp_q;

  logic                    w_fire, w_ok, w_beat_err, r_fire;
  logic                    ld_en, ld_legal, ld_last, ld_ok;
  addr_t                   ld_addr, r_nxt_addr;
  logic [data_width_p-1:0] ld_data;

  always_comb begin
    w_fire     = wvalid && wready_q;
    w_ok       = wlegal_q && in_range(waddr_q) && (wbeat_q <= {1'b0, wlen_q});
    w_beat_err = !w_ok || (wlast != (wbeat_q == {1'b0, wlen_q}));
  end

  // Beat loader: picks the address whose data is registered onto R next.
  always_comb begin
    r_fire     = rvalid_q && rready;
    r_nxt_addr = next_addr(raddr_q, rlen_q, rburst_q);
    ld_en      = 1'b0;
    ld_addr    = raddr_q;
    ld_legal   = rlegal_q;
    ld_last    = (rlen_q == '0);
    case (r_state_q)
      R_IDLE: if (LAT0 && arvalid && arready_q) begin
        ld_en    = 1'b1;
        ld_addr  = araddr;
        ld_legal = burst_legal(arlen, arburst);
        ld_last  = (arlen == '0);
      end
      R_WAIT: ld_en = (rlat_q == '0);
      R_DATA: if (r_fire && !rlast_q) begin
        ld_en   = 1'b1;
        ld_addr = r_nxt_addr;
        ld_last = ((rbeat_q + len_t'(1)) == rlen_q);
      end
      default: ;
    endcase
    ld_ok   = ld_legal && in_range(ld_addr);
    ld_data = ld_ok ? mem_q[word_idx(ld_addr)] : '0;
  end

  always_ff @(posedge aclk) begin
    if (w_fire && w_ok) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wstrb[b]) mem_q[word_idx(waddr_q)][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wburst_q  <= '0;
      wlegal_q  <= 1'b0;
      werr_q    <= 1'b0;
      wbeat_q   <= '0;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: if (awvalid && awready_q) begin
          waddr_q   <= awaddr;
          wlen_q    <= awlen;
          wburst_q  <= awburst;
          wlegal_q  <= burst_legal(awlen, awburst);
          bid_q     <= awid;
          wbeat_q   <= '0;
          werr_q    <= 1'b0;
          awready_q <= 1'b0;
          wready_q  <= 1'b1;
          w_state_q <= W_DATA;
        end
        W_DATA: if (w_fire) begin
          waddr_q <= next_addr(waddr_q, wlen_q, wburst_q);
          if (!(&wbeat_q)) wbeat_q <= wbeat_q + 1'b1;
          werr_q  <= werr_q | w_beat_err;
          if (wlast) begin
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= (werr_q || w_beat_err) ? 2'b10 : 2'b00;
            w_state_q <= W_RESP;
          end
        end
        W_RESP: if (bready) begin
          bvalid_q  <= 1'b0;
          awready_q <= 1'b1;
          w_state_q <= W_IDLE;
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rbeat_q   <= '0;
      rburst_q  <= '0;
      rlegal_q  <= 1'b0;
      rlat_q    <= '0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      if (ld_en) begin
        rdata_q <= ld_data;
        rresp_q <= ld_ok ? 2'b00 : 2'b10;
        rlast_q <= ld_last;
      end
      case (r_state_q)
        R_IDLE: if (arvalid && arready_q) begin
          raddr_q   <= araddr;
          rlen_q    <= arlen;
          rburst_q  <= arburst;
          rlegal_q  <= burst_legal(arlen, arburst);
          rid_q     <= arid;
          rbeat_q   <= '0;
          arready_q <= 1'b0;
          rlat_q    <= LATW'(LAT_LD);
          if (LAT0) begin
            rvalid_q  <= 1'b1;
            r_state_q <= R_DATA;
          end else begin
            r_state_q <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (rlat_q == '0) begin
            rvalid_q  <= 1'b1;
            r_state_q <= R_DATA;
          end else begin
            rlat_q <= rlat_q - 1'b1;
          end
        end
        R_DATA: if (r_fire) begin
          if (rlast_q) begin
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            arready_q <= 1'b1;
            r_state_q <= R_IDLE;
          end else begin
            raddr_q <= r_nxt_addr;
            rbeat_q <= rbeat_q + len_t'(1);
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

endmodule
